// File: rtl/decade_pkg.sv
// Shared opcodes, state encoding and BCD constants for the decade run controller.
package decade_pkg;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_ZERO  = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/decade_digit.sv
// One synchronous BCD digit; carry is combinational so a whole cascade steps on one edge.
module decade_digit
  import decade_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       en,
  input  logic       zero,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (zero) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/decade_seq_ctrl.sv
// Start/stop/load sequencing around a cascade of BCD digits, stopping on a target match.
//   state    | meaning
//   ST_IDLE  | stopped, LOAD allowed
//   ST_RUN   | ticks increment the count
//   ST_PAUSE | stopped mid-run, START resumes
//   ST_DONE  | one-cycle completion, commands blocked
module decade_seq_ctrl
  import decade_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [4*DIGITS-1:0] cmd_data,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] target_q, target_d;
  logic                err_q, err_d;
  logic                done_q;

  logic                accept, cnt_en, zero_cmd, load_ok, hit;
  logic [DIGITS:0]     en_w;
  logic [4*DIGITS-1:0] nxt_w;

  assign cmd_ready = (state_q != ST_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign zero_cmd  = accept && (cmd_op == OP_ZERO);
  // Any accepted command in the same cycle swallows the tick.
  assign cnt_en    = (state_q == ST_RUN) && tick && !accept;
  assign en_w[0]   = cnt_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    decade_digit u_digit (
      .clock (clock),
      .clear (clear),
      .en    (en_w[i]),
      .zero  (zero_cmd),
      .q     (count[4*i +: 4]),
      .carry (en_w[i+1])
    );
    assign nxt_w[4*i +: 4] = !en_w[i] ? count[4*i +: 4] :
                             (count[4*i +: 4] == BCD_MAX) ? 4'd0 : count[4*i +: 4] + 4'd1;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cmd_data[4*i +: 4] > BCD_MAX) load_ok = 1'b0;
    end
  end

  assign hit = cnt_en && (nxt_w == target_q);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    err_d    = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_START: if (state_q != ST_RUN) state_d = ST_RUN;
        OP_STOP:  if (state_q == ST_RUN) state_d = ST_PAUSE;
        OP_LOAD: begin
          if (state_q == ST_IDLE && load_ok) target_d = cmd_data;
          else                               err_d    = 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (hit) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      target_q <= {DIGITS{BCD_MAX}};
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      err_q    <= err_d;
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = done_q;
  assign err     = err_q;

endmodule
